// File: rtl/si_sec_filter.sv
// si_sec_filter: two-bank SI section buffer that replays only length/CRC-clean sections.
// Define SI_SEC_CRC_CHECK_EN to include the CRC32 residue check in the pass condition.
module si_sec_filter #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] si_din,
    input  logic       si_din_en,
    output logic [7:0] si_dout,
    output logic       si_dout_en,
    output logic       sec_ok,
    output logic       sec_err
);
    typedef enum logic [1:0] {EMPTY, WRITING, FULL, READING} bank_t;
    typedef enum logic {IDLE, READ} rd_t;
    localparam logic [10:0] DEP = 11'(DEPTH);

    logic [7:0]  mem [2*DEPTH];
    bank_t       bs_q [2];
    bank_t       bs_d [2];
    logic [10:0] blen_q [2];
    logic        act_q, drop_q, wb_q, ovf_q;
    logic [10:0] cnt_q;
    logic [11:0] slen_q;
    logic        vld_q, pass_q, err_q, vb_q, ok_q, serr_q;
    rd_t         st_q, st_d;
    logic        rb_q, rel_q, relb_q, old_q;
    logic [10:0] ra_q;
    logic [7:0]  rdata_q;
    logic        dv_q, hv_q;
    logic        start, claim, cb, wr, wbank, crc_ok, pass, fin;
    logic [AW-1:0] waddr;
    logic        any_full, pick_b, last, pick, rd, done;

    assign start    = si_din_en & ~act_q;
    assign fin      = act_q & ~si_din_en;
    assign wr       = si_din_en & (start ? claim : ~drop_q & (cnt_q < DEP));
    assign wbank    = start ? cb : wb_q;
    assign waddr    = start ? '0 : cnt_q[AW-1:0];
    assign pass     = ~drop_q & (cnt_q >= 11'd7) & ({1'b0, cnt_q} == slen_q + 12'd3) & ~ovf_q & crc_ok;
    assign any_full = (bs_q[0] == FULL) | (bs_q[1] == FULL);
    assign pick_b   = (bs_q[0] == FULL && bs_q[1] == FULL) ? old_q : (bs_q[1] == FULL);
    assign last     = ra_q == blen_q[rb_q] - 11'd1;

`ifdef SI_SEC_CRC_CHECK_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = (r[31] ^ d[i]) ? {r[30:0], 1'b0} ^ 32'h04C11DB7 : {r[30:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst)
            crc_q <= '1;
        else if (si_din_en)
            crc_q <= crc_byte(start ? '1 : crc_q, si_din);

    assign crc_ok = crc_q == '0;
`else
    assign crc_ok = 1'b1;
`endif

    // Reader release is applied before verdicts and claims so a freed bank is claimable at once
    always_comb begin
        bs_d  = bs_q;
        claim = 1'b0;
        cb    = 1'b0;
        if (rel_q)
            bs_d[relb_q] = EMPTY;
        if (vld_q)
            bs_d[vb_q] = pass_q ? FULL : EMPTY;
        if (start) begin
            claim = (bs_d[0] == EMPTY) | (bs_d[1] == EMPTY);
            cb    = bs_d[0] != EMPTY;
            if (claim)
                bs_d[cb] = WRITING;
        end
        if (pick)
            bs_d[pick_b] = READING;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            act_q  <= 1'b0;
            drop_q <= 1'b0;
            wb_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            slen_q <= '0;
            vld_q  <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= 1'b0;
            vb_q   <= 1'b0;
            ok_q   <= 1'b0;
            serr_q <= 1'b0;
            blen_q <= '{default: '0};
        end else begin
            act_q  <= si_din_en;
            vld_q  <= fin & ~drop_q;
            err_q  <= fin & ~pass;
            pass_q <= pass;
            vb_q   <= wb_q;
            ok_q   <= vld_q & pass_q;
            serr_q <= err_q;
            if (fin & pass)
                blen_q[wb_q] <= cnt_q;
            if (si_din_en) begin
                cnt_q <= start ? 11'd1 : (&cnt_q ? cnt_q : cnt_q + 11'd1);
                if (start) begin
                    drop_q <= ~claim;
                    wb_q   <= cb;
                    ovf_q  <= 1'b0;
                end else if (cnt_q >= DEP)
                    ovf_q <= 1'b1;
                if (~start && cnt_q == 11'd1)
                    slen_q[11:8] <= si_din[3:0];
                if (~start && cnt_q == 11'd2)
                    slen_q[7:0] <= si_din;
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            st_q <= IDLE;
        else
            st_q <= st_d;

    always_comb
        st_d = (st_q == IDLE) ? (any_full ? READ : IDLE) : (last ? IDLE : READ);

    always_comb begin
        pick = (st_q == IDLE) & any_full;
        rd   = st_q == READ;
        done = rd & last;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bs_q   <= '{default: EMPTY};
            rb_q   <= 1'b0;
            ra_q   <= '0;
            rel_q  <= 1'b0;
            relb_q <= 1'b0;
            old_q  <= 1'b0;
            dv_q   <= 1'b0;
            hv_q   <= 1'b0;
        end else begin
            bs_q   <= bs_d;
            rel_q  <= done;
            relb_q <= rb_q;
            dv_q   <= rd;
            if (rd)
                hv_q <= 1'b1;
            if (pick) begin
                rb_q <= pick_b;
                ra_q <= '0;
            end else if (rd)
                ra_q <= ra_q + 11'd1;
            if (vld_q & pass_q)
                old_q <= (bs_q[~vb_q] == FULL) ? ~vb_q : vb_q;
        end

    always_ff @(posedge clk) begin
        if (wr)
            mem[{wbank, waddr}] <= si_din;
        if (rd)
            rdata_q <= mem[{rb_q, ra_q[AW-1:0]}];
    end

    assign si_dout    = hv_q ? rdata_q : '0;
    assign si_dout_en = dv_q;
    assign sec_ok     = ok_q;
    assign sec_err    = serr_q;
endmodule

// File: tb/tb_si_sec_filter.sv
// tb_si_sec_filter: scoreboard bench for si_sec_filter verdicts, latency and replay data.
module tb_si_sec_filter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] si_din = '0;
    logic       si_din_en = 1'b0;
    logic [7:0] si_dout;
    logic       si_dout_en, sec_ok, sec_err;
    int         checks = 0, errors = 0, cyc = 0;
    logic [7:0] sec[$], exp_q[$], mon_e;
    int         oks[$], errs[$], starts[$], ends[$];
    logic       prev_en = 1'b0;

    si_sec_filter dut (
        .clk(clk), .rst(rst), .si_din(si_din), .si_din_en(si_din_en),
        .si_dout(si_dout), .si_dout_en(si_dout_en), .sec_ok(sec_ok), .sec_err(sec_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    // Scoreboard: every output byte must match the next byte of a section expected to pass
    always @(negedge clk) begin
        if (si_dout_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got byte %02h at cycle %0d, required no output", si_dout, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (si_dout !== mon_e) begin
                    errors++;
                    $display("FAIL out_byte: got %02h at cycle %0d, required %02h", si_dout, cyc, mon_e);
                end
            end
            if (!prev_en) starts.push_back(cyc);
        end else if (prev_en) ends.push_back(cyc - 1);
        if (sec_ok === 1'b1) oks.push_back(cyc);
        if (sec_err === 1'b1) errs.push_back(cyc);
        prev_en = (si_dout_en === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        c ^= {d, 24'b0};
        for (int i = 0; i < 8; i++) c = c[31] ? (c << 1) ^ 32'h04C11DB7 : c << 1;
        return c;
    endfunction

    function automatic int first(input int q[$]);
        return q.size() ? q[0] : -1;
    endfunction

    task automatic make_sec(input int n, input int sl, input int seed);
        logic [31:0] c;
        sec.delete();
        sec.push_back(8'h42);
        sec.push_back({4'hF, 4'(sl >> 8)});
        sec.push_back(8'(sl));
        for (int i = 3; i < n - 4; i++) sec.push_back(8'(i * 7 + 3 + seed));
        if (n < 7) begin
            while (sec.size() < n) sec.push_back(8'h5A);
        end else begin
            c = '1;
            foreach (sec[i]) c = crc_model(c, sec[i]);
            for (int k = 3; k >= 0; k--) sec.push_back(8'(c >> (8 * k)));
        end
    endtask

    task automatic send(input bit exp_pass, output int last);
        last = -1;
        foreach (sec[i]) begin
            @(negedge clk);
            si_din = sec[i];
            si_din_en = 1'b1;
            last = cyc + 1;
            if (exp_pass) exp_q.push_back(sec[i]);
        end
        @(negedge clk);
        si_din_en = 1'b0;
    endtask

    task automatic clear();
        oks.delete(); errs.delete(); starts.delete(); ends.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (si_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h, required 00", si_dout); end
        if (si_dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en: got %b, required 0", si_dout_en); end
        if (sec_ok !== 1'b0) begin errors++; $display("FAIL reset_sec_ok: got %b, required 0", sec_ok); end
        if (sec_err !== 1'b0) begin errors++; $display("FAIL reset_sec_err: got %b, required 0", sec_err); end
        rst = 1'b0;
    endtask

    task automatic test_valid();
        int n;
        clear();
        while (cyc < 8) @(negedge clk);
        make_sec(40, 37, 0);
        send(1, n);
        repeat (60) @(negedge clk);
        checks += 5;
        if (oks.size() != 1 || first(oks) != n + 2) begin errors++; $display("FAIL valid_ok: got %0d pulses first at %0d, required 1 at %0d", oks.size(), first(oks), n + 2); end
        if (errs.size() != 0) begin errors++; $display("FAIL valid_err: got %0d pulses, required 0", errs.size()); end
        if (starts.size() != 1 || first(starts) != n + 4) begin errors++; $display("FAIL valid_start: got %0d bursts first at %0d, required 1 at %0d", starts.size(), first(starts), n + 4); end
        if (first(ends) != n + 43) begin errors++; $display("FAIL valid_end: got %0d, required %0d", first(ends), n + 43); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL valid_missing: got %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_bad_crc();
        int n;
        clear();
        make_sec(40, 37, 1);
        sec[39] ^= 8'h01;
`ifdef SI_SEC_CRC_CHECK_EN
        send(0, n);
        repeat (60) @(negedge clk);
        checks += 3;
        if (errs.size() != 1 || first(errs) != n + 2) begin errors++; $display("FAIL crc_err: got %0d pulses first at %0d, required 1 at %0d", errs.size(), first(errs), n + 2); end
        if (oks.size() != 0) begin errors++; $display("FAIL crc_ok: got %0d pulses, required 0", oks.size()); end
        if (starts.size() != 0) begin errors++; $display("FAIL crc_out: got %0d bursts, required 0", starts.size()); end
`else
        send(1, n);
        repeat (60) @(negedge clk);
        checks += 3;
        if (oks.size() != 1 || first(oks) != n + 2) begin errors++; $display("FAIL nocrc_ok: got %0d pulses first at %0d, required 1 at %0d", oks.size(), first(oks), n + 2); end
        if (first(starts) != n + 4) begin errors++; $display("FAIL nocrc_start: got %0d, required %0d", first(starts), n + 4); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL nocrc_missing: got %0d bytes left, required 0", exp_q.size()); end
`endif
    endtask

    task automatic test_length();
        int n;
        clear();
        make_sec(40, 48, 2);
        send(0, n);
        repeat (20) @(negedge clk);
        checks += 2;
        if (errs.size() != 1 || first(errs) != n + 2) begin errors++; $display("FAIL len_err: got %0d pulses first at %0d, required 1 at %0d", errs.size(), first(errs), n + 2); end
        if (oks.size() != 0 || starts.size() != 0) begin errors++; $display("FAIL len_out: got %0d ok %0d bursts, required 0 0", oks.size(), starts.size()); end
        clear();
        make_sec(6, 3, 0);
        send(0, n);
        repeat (20) @(negedge clk);
        checks += 2;
        if (errs.size() != 1 || first(errs) != n + 2) begin errors++; $display("FAIL short_err: got %0d pulses first at %0d, required 1 at %0d", errs.size(), first(errs), n + 2); end
        if (oks.size() != 0 || starts.size() != 0) begin errors++; $display("FAIL short_out: got %0d ok %0d bursts, required 0 0", oks.size(), starts.size()); end
        clear();
        make_sec(7, 4, 0);
        send(1, n);
        repeat (20) @(negedge clk);
        checks += 3;
        if (oks.size() != 1 || first(oks) != n + 2) begin errors++; $display("FAIL min_ok: got %0d pulses first at %0d, required 1 at %0d", oks.size(), first(oks), n + 2); end
        if (first(ends) != n + 10) begin errors++; $display("FAIL min_end: got %0d, required %0d", first(ends), n + 10); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL min_missing: got %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n[3];
        clear();
        for (int k = 0; k < 3; k++) begin
            make_sec(300, 297, 10 * k);
            send(k < 2, n[k]);
        end
        repeat (700) @(negedge clk);
        checks += 5;
        if (oks.size() != 2 || first(oks) != n[0] + 2 || oks[1] != n[1] + 2) begin errors++; $display("FAIL b2b_ok: got %0d pulses first at %0d, required 2 at %0d,%0d", oks.size(), first(oks), n[0] + 2, n[1] + 2); end
        if (errs.size() != 1 || first(errs) != n[2] + 2) begin errors++; $display("FAIL b2b_drop: got %0d pulses first at %0d, required 1 at %0d", errs.size(), first(errs), n[2] + 2); end
        if (starts.size() != 2 || first(starts) != n[0] + 4) begin errors++; $display("FAIL b2b_start: got %0d bursts first at %0d, required 2 at %0d", starts.size(), first(starts), n[0] + 4); end
        if (starts.size() != 2 || starts[1] != first(ends) + 2) begin errors++; $display("FAIL b2b_gap: got second start %0d after end %0d, required one idle cycle", starts.size() > 1 ? starts[1] : -1, first(ends)); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        int n;
        clear();
        make_sec(1030, 1027, 3);
        send(0, n);
        repeat (20) @(negedge clk);
        checks += 2;
        if (errs.size() != 1 || first(errs) != n + 2) begin errors++; $display("FAIL ovf_err: got %0d pulses first at %0d, required 1 at %0d", errs.size(), first(errs), n + 2); end
        if (oks.size() != 0 || starts.size() != 0) begin errors++; $display("FAIL ovf_out: got %0d ok %0d bursts, required 0 0", oks.size(), starts.size()); end
        clear();
        make_sec(40, 37, 4);
        send(1, n);
        repeat (60) @(negedge clk);
        checks += 2;
        if (oks.size() != 1 || first(oks) != n + 2 || first(starts) != n + 4) begin errors++; $display("FAIL ovf_next: got ok %0d start %0d, required %0d %0d", first(oks), first(starts), n + 2, n + 4); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_missing: got %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_replay();
        int n, k;
        clear();
        make_sec(100, 97, 5);
        send(1, n);
        k = 0;
        for (int t = 0; t < 200 && k < 20; t++) begin
            @(posedge clk);
            #1;
            if (si_dout_en === 1'b1) k++;
        end
        checks++;
        if (k != 20) begin errors++; $display("FAIL rr_reach: got %0d output bytes, required 20", k); end
        rst = 1'b1;
        #1;
        checks += 2;
        if (si_dout_en !== 1'b0) begin errors++; $display("FAIL rr_en_drop: got %b, required 0", si_dout_en); end
        if (si_dout !== 8'h00) begin errors++; $display("FAIL rr_dout: got %02h, required 00", si_dout); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear();
        make_sec(40, 37, 6);
        send(1, n);
        repeat (60) @(negedge clk);
        checks += 3;
        if (oks.size() != 1 || first(oks) != n + 2) begin errors++; $display("FAIL rr_ok: got %0d pulses first at %0d, required 1 at %0d", oks.size(), first(oks), n + 2); end
        if (starts.size() != 1 || first(starts) != n + 4 || first(ends) != n + 43) begin errors++; $display("FAIL rr_window: got %0d..%0d, required %0d..%0d", first(starts), first(ends), n + 4, n + 43); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL rr_missing: got %0d bytes left, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bad_crc();
        test_length();
        test_back_to_back();
        test_overflow();
        test_reset_replay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
